xpb_lut_bank: RTL
=================

// Module: xpb_lut_bank
// PURPOSE
//  Parametrised, runtime-loadable bank of NUM_LUT XPB lookup tables: each lane maps an IDX_W-bit
//  digit to a DATA_W-bit precomputed reduction constant (x*2^k mod N) with one registered cycle of
//  latency. Constants stream in through a LOAD_W-bit handshake port, so the modulus can change
//  without resynthesis. Sits between the square-digit split and the XPB reduction adder tree.
// PARAMETERS
//  NUM_LUT  4     number of independent tables / lookup lanes
//  IDX_W    5     index width per lane; table depth ENTRIES = 2**IDX_W
//  DATA_W   1024  constant width
//  LOAD_W   64    load beat width; DATA_W % LOAD_W == 0; BEATS = DATA_W/LOAD_W
// PORTS
//  clk          in   1                  clock, all logic on posedge
//  rst_n        in   1                  asynchronous active-low reset
//  load_start   in   1                  begin loading table load_lut (sampled in IDLE only)
//  load_lut     in   clog2(NUM_LUT)     table selected at load_start
//  load_valid   in   1                  load beat present
//  load_data    in   LOAD_W             beat data, LS chunk of an entry first
//  load_ready   out  1                  beat accepted when load_valid & load_ready
//  load_done    out  1                  one-cycle pulse: selected table committed
//  busy         out  1                  loader not IDLE
//  lut_loaded   out  NUM_LUT            per-table valid flag
//  lut_valid_in in   1                  lookup request, all lanes together
//  idx_in       in   NUM_LUT*IDX_W      lane i index = idx_in[i*IDX_W +: IDX_W]
//  lut_valid_out out 1                  lookup result valid
//  data_out     out  NUM_LUT*DATA_W     lane i result = data_out[i*DATA_W +: DATA_W]
// BEHAVIOUR
//  Reset (async assert, sync release): load_ready/load_done/busy/lut_valid_out = 0, data_out = 0,
//   lut_loaded = 0, FSM = IDLE, beat/entry counters = 0. Table storage itself is not reset.
//  Loader FSM: IDLE -> LOAD on load_start; LOAD -> COMMIT after last beat of entry ENTRIES-1;
//   COMMIT -> IDLE after one cycle. busy=1 in LOAD and COMMIT.
//  IDLE: load_ready=0; load_start latches load_lut, clears lut_loaded[load_lut] next cycle,
//   entry counter := 1, beat counter := 0. load_lut >= NUM_LUT: start ignored.
//  LOAD: load_ready=1. Each accepted beat shifts into the DATA_W assembly register at bit position
//   beat*LOAD_W; on beat BEATS-1 the assembled word is written to table[lut][entry], entry++,
//   beat := 0. Gaps in load_valid stall counters, no data lost. ENTRIES-1 entries * BEATS beats
//   (default 31*16 = 496) per load.
//  COMMIT: load_ready=0, load_done=1 for this single cycle, lut_loaded[lut] := 1.
//  Entry 0 is never stored: index 0 always returns 0 in every lane.
//  load_start while busy: ignored, no effect on the load in progress.
//  Lookup: always accepted (no ready). Cycle after lut_valid_in=1: lut_valid_out=1 and lane i =
//   (lut_loaded[i] && idx!=0) ? table[i][idx] : 0, using lut_loaded as of the request cycle.
//   lut_valid_in=0: lut_valid_out=0 next cycle, data_out holds previous value.
//  Lookup to a table under load returns 0 for that lane only; other lanes unaffected.
//  Same-cycle table write and lookup of same entry: lookup sees old content (irrelevant as lane
//   returns 0 while loading).
//  Reset mid-load: FSM to IDLE, all lut_loaded cleared; partially written entries are stale and
//   unreachable until a full reload sets the flag.
// TESTING
//  Reset: after rst_n release all outputs 0, lut_loaded=4'b0000, lookup idx=5 -> all lanes 0.
//  Load LUT0 with entry k = {16{k[63:0]}} (496 back-to-back beats) -> load_done pulse cycle after
//   last beat, lut_loaded=4'b0001; lookup idx0=7 -> lane0 = {16{64'h7}} one cycle later.
//  Index 0: after loading all LUTs, idx_in all zero with lut_valid_in=1 -> data_out = 0.
//  Lookup during LUT1 load (LUT0 loaded): lane1 = 0, lane0 = table value; after load_done lane1
//   returns loaded data.
//  load_valid toggled 1/0 every cycle through a full load -> identical table contents, load lasts
//   ~992 cycles; load_start pulsed mid-load with load_lut=2 -> ignored, LUT2 flag stays 0.
//  rst_n asserted after 200 beats of LUT3 load -> busy=0, lut_loaded=0 immediately; lookups
//   return 0 until a fresh complete load.

Source files
------------

// File: rtl/xpb_lut_bank.sv
// rtl/xpb_lut_bank.sv - runtime-loadable bank of XPB reduction-constant lookup tables
module xpb_lut_bank #(
    parameter int NUM_LUT = 4,
    parameter int IDX_W   = 5,
    parameter int DATA_W  = 1024,
    parameter int LOAD_W  = 64,
    localparam int LUT_W  = (NUM_LUT > 1) ? $clog2(NUM_LUT) : 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        load_start,
    input  logic [LUT_W-1:0]            load_lut,
    input  logic                        load_valid,
    input  logic [LOAD_W-1:0]           load_data,
    output logic                        load_ready,
    output logic                        load_done,
    output logic                        busy,
    output logic [NUM_LUT-1:0]          lut_loaded,
    input  logic                        lut_valid_in,
    input  logic [NUM_LUT*IDX_W-1:0]    idx_in,
    output logic                        lut_valid_out,
    output logic [NUM_LUT*DATA_W-1:0]   data_out
);

    localparam int ENTRIES = 2**IDX_W;
    localparam int BEATS   = DATA_W / LOAD_W;
    localparam int BEAT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [IDX_W-1:0]  LAST_ENTRY = IDX_W'(ENTRIES - 1);
    localparam logic [LUT_W:0]    NUM_LUT_V  = (LUT_W + 1)'(NUM_LUT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    state_t                     r_state;
    logic [LUT_W-1:0]           r_lut;
    logic [IDX_W-1:0]           r_entry;
    logic [BEAT_W-1:0]          r_beat;
    logic [DATA_W-1:0]          r_asm;
    logic [NUM_LUT-1:0]         r_loaded;
    logic                       r_done;
    logic                       r_valid_out;
    logic [NUM_LUT*DATA_W-1:0]  r_data_out;
    logic [DATA_W-1:0]          r_table [NUM_LUT][ENTRIES];

    logic [LUT_W:0]             w_lut_ext;
    logic                       w_start_ok;
    logic                       w_beat_acc;
    logic                       w_last_beat;
    logic [DATA_W-1:0]          w_asm_next;
    logic [IDX_W-1:0]           w_idx [NUM_LUT];

    // Out-of-range table selects are dropped rather than aliased onto a real table.
    assign w_lut_ext   = {1'b0, load_lut};
    assign w_start_ok  = load_start && (w_lut_ext < NUM_LUT_V);
    assign w_beat_acc  = (r_state == S_LOAD) && load_valid;
    assign w_last_beat = w_beat_acc && (r_beat == LAST_BEAT);

    genvar g;
    generate
        for (g = 0; g < NUM_LUT; g++) begin : g_idx
            assign w_idx[g] = idx_in[g*IDX_W +: IDX_W];
        end
    endgenerate

    // Assembly word with the current beat merged in at its chunk position (LS chunk first).
    always_comb begin
        w_asm_next = r_asm;
        for (int b = 0; b < BEATS; b++) begin
            if (r_beat == BEAT_W'(b)) begin
                w_asm_next[b*LOAD_W +: LOAD_W] = load_data;
            end
        end
    end

    // Loader FSM: start latches the table, beats fill entries 1..ENTRIES-1, commit sets the flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_lut    <= '0;
            r_entry  <= '0;
            r_beat   <= '0;
            r_asm    <= '0;
            r_loaded <= '0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_ok) begin
                        r_lut              <= load_lut;
                        r_loaded[load_lut] <= 1'b0;
                        r_entry            <= IDX_W'(1);
                        r_beat             <= '0;
                        r_state            <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (w_beat_acc) begin
                        r_asm <= w_asm_next;
                        if (r_beat == LAST_BEAT) begin
                            r_beat  <= '0;
                            r_entry <= r_entry + IDX_W'(1);
                            if (r_entry == LAST_ENTRY) begin
                                r_state <= S_COMMIT;
                                r_done  <= 1'b1;
                            end
                        end else begin
                            r_beat <= r_beat + BEAT_W'(1);
                        end
                    end
                end
                S_COMMIT: begin
                    r_loaded[r_lut] <= 1'b1;
                    r_state         <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Table storage is deliberately unreset; the per-table flag gates visibility instead.
    always_ff @(posedge clk) begin
        if (w_last_beat) begin
            r_table[r_lut][r_entry] <= w_asm_next;
        end
    end

    // Registered lookup: unloaded tables and index 0 read as zero; idle cycles hold the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_out <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_valid_out <= lut_valid_in;
            if (lut_valid_in) begin
                for (int i = 0; i < NUM_LUT; i++) begin
                    if (r_loaded[i] && (w_idx[i] != '0)) begin
                        r_data_out[i*DATA_W +: DATA_W] <= r_table[i][w_idx[i]];
                    end else begin
                        r_data_out[i*DATA_W +: DATA_W] <= '0;
                    end
                end
            end
        end
    end

    assign load_ready    = (r_state == S_LOAD);
    assign busy          = (r_state != S_IDLE);
    assign load_done     = r_done;
    assign lut_loaded    = r_loaded;
    assign lut_valid_out = r_valid_out;
    assign data_out      = r_data_out;

endmodule
